// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM response, buffers it across
// write-back stalls, aligns/extends load data and drives the write-back and forwarding buses.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 75,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_TO_DS_BUS_WD = 39
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  logic                       ms_valid;
  logic                       buf_valid;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus_p1;
  logic [31:0]                buf_data_p1;

  logic        mem_req;
  logic [2:0]  load_op;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  logic        ms_ready_go;
  logic        buf_capture;
  logic [31:0] load_word;
  logic [31:0] final_result;

  function automatic logic [31:0] load_align(input logic [2:0]  op,
                                             input logic [1:0]  addr,
                                             input logic [31:0] word);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [31:0]        res;
    case (addr)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    half_s = addr[1] ? word[31:16] : word[15:0];
    case (op)
      3'b001:  res = 32'(byte_s);
      3'b101:  res = {24'd0, byte_s};
      3'b010:  res = 32'(half_s);
      3'b110:  res = {16'd0, half_s};
      default: res = word;
    endcase
    return res;
  endfunction

  assign {mem_req, load_op, res_from_mem, gr_we, dest, alu_result, pc} = ms_bus_p1;

  assign ms_ready_go    = !mem_req || buf_valid || data_sram_data_ok;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  // Response arrived while write-back is stalled: hold it so rdata may change afterwards.
  assign buf_capture = ms_valid && mem_req && !buf_valid && data_sram_data_ok && !ws_allowin;

  assign load_word    = buf_valid ? buf_data_p1 : data_sram_rdata;
  assign final_result = res_from_mem ? load_align(load_op, alu_result[1:0], load_word)
                                     : alu_result;

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
  assign ms_to_ds_bus = {ms_valid && gr_we && (dest != 5'd0) && ms_ready_go,
                         ms_valid && res_from_mem && !ms_ready_go,
                         dest, final_result};

  // ---- stage p1: instruction held in MEM ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid  <= 1'b0;
      buf_valid <= 1'b0;
      ms_bus_p1 <= '0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
        ms_bus_p1 <= es_to_ms_bus;
      end
      if (ms_allowin) begin
        buf_valid <= 1'b0;
      end else if (buf_capture) begin
        buf_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_capture) begin
      buf_data_p1 <= data_sram_rdata;
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage of the five-stage LoongArch-style core, between the execute stage and the write-back stage. Holds one instruction. Waits for the data-SRAM response of any load/store issued in EX, buffers the returned data if write-back stalls, and aligns and sign/zero-extends load data. Presents the final result to write-back, and a forwarding/hazard bus to decode.

Parameters:
ES_TO_MS_BUS_WD, 75, width of es_to_ms_bus
MS_TO_WS_BUS_WD, 70, width of ms_to_ws_bus
MS_TO_DS_BUS_WD, 39, width of ms_to_ds_bus

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
ws_allowin  input  1  write-back can accept this cycle
ms_allowin  output  1  this stage can accept from execute
es_to_ms_valid  input  1  execute offers an instruction
es_to_ms_bus  input  75  [74] mem_req, [73:71] load_op, [70] res_from_mem, [69] gr_we, [68:64] dest, [63:32] alu_result, [31:0] pc
ms_to_ws_valid  output  1  instruction offered to write-back
ms_to_ws_bus  output  70  [69] gr_we, [68:64] dest, [63:32] final_result, [31:0] pc
ms_to_ds_bus  output  39  [38] fwd_valid, [37] load_pending, [36:32] dest, [31:0] final_result
data_sram_data_ok  input  1  response for the single outstanding data request
data_sram_rdata  input  32  response data, valid with data_ok

Behaviour:
- Reset is asynchronous, active-low: ms_valid=0, buf_valid=0, bus register=0. ms_allowin=1, ms_to_ws_valid=0, ms_to_ds_bus=0 while in reset.
- State per held instruction: EMPTY (ms_valid=0); WAIT (ms_valid & mem_req & !buf_valid); READY (ms_valid & (!mem_req | buf_valid)).
- ms_ready_go = !mem_req | buf_valid | data_sram_data_ok.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go.
- On ms_allowin: ms_valid <= es_to_ms_valid. Bus register loads only when es_to_ms_valid & ms_allowin. buf_valid cleared on any ms_allowin.
- WAIT with data_sram_data_ok & !ws_allowin: rdata captured into buf_data, buf_valid <= 1, move to READY.
- WAIT with data_ok & ws_allowin: pass-through in the same cycle using live rdata; buffer not set.
- data_ok while EMPTY or READY (orphan, including after reset) is ignored.
- Stores set mem_req, gr_we=0, res_from_mem=0. They wait for data_ok but return no result.
- Load data source: buf_valid ? buf_data : data_sram_rdata. addr = alu_result[1:0].
- load_op 000 ld.w: word.
- load_op 001 ld.b: byte[addr], sign-extended.
- load_op 101 ld.bu: byte[addr], zero-extended.
- load_op 010 ld.h: half[addr[1]], sign-extended.
- load_op 110 ld.hu: half[addr[1]], zero-extended.
- Other load_op codes behave as ld.w. Misalignment is never checked here (EX guarantees alignment).
- final_result = res_from_mem ? aligned load data : alu_result.
- ms_to_ds_bus: fwd_valid = ms_valid & gr_we & (dest!=0) & ms_ready_go. load_pending = ms_valid & res_from_mem & !ms_ready_go. dest, final_result as above.
- Latency: non-memory op 1 cycle in stage; memory op 1 cycle after data_ok at earliest. Throughput 1/cycle for back-to-back ALU ops.
- Reset mid-WAIT: instruction dropped, the late data_ok is discarded.

Test Plan:
- ALU op, pc=0x1c000000, alu_result=0x12345678, gr_we=1, dest=5, ws_allowin=1 -> next cycle ms_to_ws_valid=1, bus {1,5,0x12345678,0x1c000000}; fwd_valid=1.
- ld.b addr=0x...03, data_ok same cycle as held, rdata=0x80FF7F01 -> final_result=0xFFFFFF80; ld.bu -> 0x00000080; ld.hu addr[1]=1 -> 0x000080FF; ld.h addr[1]=0 -> 0x00007F01.
- Load held, data_ok delayed 3 cycles -> ms_to_ws_valid=0, ms_allowin=0, load_pending=1 for 3 cycles; then valid with data in the data_ok cycle.
- Load, data_ok=1 with rdata=0xDEADBEEF while ws_allowin=0; rdata then changes to 0 and ws_allowin rises 2 cycles later -> final_result=0xDEADBEEF, output exactly once.
- Store with mem_req=1 -> no result, gr_we=0 and fwd_valid=0; stage stalls until data_ok, then drains.
- resetn low during WAIT, stray data_ok after release -> ms_valid=0, ms_to_ws_valid stays 0, next es instruction accepted normally.
